// File: rtl/pipeline_pkg.sv
// Shared MEM/WB pipeline definitions.
// Holds the register-file geometry and the MEM/WB bundle type, so the
// MEM/WB pipeline register and the write-back/register-file block agree
// on one layout.
package pipeline_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] target_data;
  } wb_bundle_t;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port.
// Ports:
//   rd_addr_i  - register index being read
//   arr_data_i - stored contents of that register (from the array)
//   wr_en_i    - qualified write enable for this cycle (already excludes r0 and reset)
//   wr_addr_i  - register index being written this cycle
//   wr_data_i  - value being written this cycle
//   rd_data_o  - read result: 0 for r0, bypassed write data on a match, else stored value
module regfile_read_port #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] arr_data_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);
  import pipeline_pkg::*;

  always_comb begin
    rd_data_o = arr_data_i;
    if (rd_addr_i == REG_ZERO) begin
      rd_data_o = '0;
    end else if (wr_en_i && (rd_addr_i == wr_addr_i)) begin
      // Same-cycle bypass: ID sees the value WB commits on this edge.
      rd_data_o = wr_data_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage merged with the 32x32 architectural register file.
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   RegWrite_i, MemtoReg_i,
//   Result_i, MemData_i,
//   target_data_i         - registered MEM/WB bundle
//   rs_addr_i, rt_addr_i  - ID-stage read indices
//   rs_data_o, rt_data_o  - combinational read data with write bypass
//   wb_data_o             - selected write-back value (to forwarding unit)
//   wr_count_o            - number of committed register writes
module wb_regfile #(
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int ADDR_W   = pipeline_pkg::ADDR_W,
  parameter int NUM_REGS = pipeline_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] Result_i,
  input  logic [DATA_W-1:0] MemData_i,
  input  logic [ADDR_W-1:0] target_data_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [31:0]       wr_count_o
);
  import pipeline_pkg::*;

  wb_bundle_t        wb;
  logic              we;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;

  always_comb begin
    wb.reg_write   = RegWrite_i;
    wb.mem_to_reg  = MemtoReg_i;
    wb.result      = Result_i;
    wb.mem_data    = MemData_i;
    wb.target_data = target_data_i;
  end

  assign wb_data_o = wb.mem_to_reg ? wb.mem_data : wb.result;

  // Reset also gates the bypass, so reads during reset come from the array.
  assign we = wb.reg_write && (wb.target_data != REG_ZERO) && !rst;

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (we) begin
      regs_d[wb.target_data] = wb_data_o;
      wr_count_d             = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count_o = wr_count_q;

  regfile_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rs_port (
    .rd_addr_i (rs_addr_i),
    .arr_data_i(regs_q[rs_addr_i]),
    .wr_en_i   (we),
    .wr_addr_i (wb.target_data),
    .wr_data_i (wb_data_o),
    .rd_data_o (rs_data_o)
  );

  regfile_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rt_port (
    .rd_addr_i (rt_addr_i),
    .arr_data_i(regs_q[rt_addr_i]),
    .wr_en_i   (we),
    .wr_addr_i (wb.target_data),
    .wr_data_i (wb_data_o),
    .rd_data_o (rt_data_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_i;
  logic        MemtoReg_i;
  logic [31:0] Result_i;
  logic [31:0] MemData_i;
  logic [4:0]  target_data_i;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic [31:0] rs_data_o;
  logic [31:0] rt_data_o;
  logic [31:0] wb_data_o;
  logic [31:0] wr_count_o;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .RegWrite_i   (RegWrite_i),
    .MemtoReg_i   (MemtoReg_i),
    .Result_i     (Result_i),
    .MemData_i    (MemData_i),
    .target_data_i(target_data_i),
    .rs_addr_i    (rs_addr_i),
    .rt_addr_i    (rt_addr_i),
    .rs_data_o    (rs_data_o),
    .rt_data_o    (rt_data_o),
    .wb_data_o    (wb_data_o),
    .wr_count_o   (wr_count_o)
  );

  // Applies one MEM/WB bundle plus read addresses on the falling edge.
  task automatic drive(input logic rw, input logic m2r, input logic [31:0] res,
                       input logic [31:0] mem, input logic [4:0] tgt,
                       input logic [4:0] rs, input logic [4:0] rt);
    @(negedge clk);
    RegWrite_i    = rw;
    MemtoReg_i    = m2r;
    Result_i      = res;
    MemData_i     = mem;
    target_data_i = tgt;
    rs_addr_i     = rs;
    rt_addr_i     = rt;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h1234, 32'h0, 5'd5, 5'd5, 5'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
    sb.push_back('{"pre_reset_r5", 32'h1234});
    sb.push_back('{"pre_reset_count", 32'd1});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{"reset_r5", 32'h0});
    sb.push_back('{"reset_count", 32'h0});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mux_commit();
    drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h11111111, 5'd8, 5'd8, 5'd0);
    sb.push_back('{"mux_alu_wb_data", 32'hDEADBEEF});
    e = sb.pop_front(); total++;
    if (wb_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wb_data_o, e.exp); else passed++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0);
    sb.push_back('{"commit_alu_r8", 32'hDEADBEEF});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h11111111, 5'd8, 5'd0, 5'd0);
    sb.push_back('{"mux_mem_wb_data", 32'h11111111});
    e = sb.pop_front(); total++;
    if (wb_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wb_data_o, e.exp); else passed++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd8);
    sb.push_back('{"commit_mem_r8", 32'h11111111});
    sb.push_back('{"mux_count", 32'd2});
    e = sb.pop_front(); total++;
    if (rt_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rt_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
  endtask

  task automatic test_bypass();
    drive(1'b1, 1'b0, 32'hA, 32'h0, 5'd9, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 32'hB, 32'h0, 5'd9, 5'd9, 5'd9);
    sb.push_back('{"bypass_rs_same", 32'hB});
    sb.push_back('{"bypass_rt_same", 32'hB});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (rt_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rt_data_o, e.exp); else passed++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    sb.push_back('{"bypass_rs_next", 32'hB});
    sb.push_back('{"bypass_rt_next", 32'hB});
    sb.push_back('{"bypass_count", 32'd4});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (rt_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rt_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
  endtask

  task automatic test_reg_zero();
    drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    sb.push_back('{"r0_same_cycle", 32'h0});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    sb.push_back('{"r0_next_cycle", 32'h0});
    sb.push_back('{"r0_count", 32'd4});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
  endtask

  task automatic test_disabled_write();
    drive(1'b1, 1'b0, 32'h33, 32'h0, 5'd3, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 32'h0, 32'h55, 5'd3, 5'd3, 5'd0);
    sb.push_back('{"disabled_no_bypass", 32'h33});
    sb.push_back('{"disabled_wb_data", 32'h55});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (wb_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wb_data_o, e.exp); else passed++;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    sb.push_back('{"disabled_r3_kept", 32'h33});
    sb.push_back('{"disabled_count", 32'd5});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = $urandom();
    // Each cycle writes r(10+i) while rt reads the register written the cycle before.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i[0], vals[i], vals[i], 5'(10 + i), 5'(10 + i), 5'(9 + i));
      sb.push_back('{"b2b_rs_bypass", vals[i]});
      sb.push_back('{"b2b_rt_prev", (i == 0) ? 32'hB : vals[i-1]});
      e = sb.pop_front(); total++;
      if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
      e = sb.pop_front(); total++;
      if (rt_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rt_data_o, e.exp); else passed++;
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd13);
    sb.push_back('{"b2b_r10", vals[0]});
    sb.push_back('{"b2b_r13", vals[3]});
    sb.push_back('{"b2b_count", 32'd9});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (rt_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rt_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
  endtask

  task automatic test_reset_mid_write();
    drive(1'b1, 1'b0, 32'h66, 32'h0, 5'd4, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 32'h77, 32'h0, 5'd4, 5'd4, 5'd9);
    rst = 1'b1;
    #1;
    sb.push_back('{"rst_bypass_off", 32'h66});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    @(posedge clk); #1;
    sb.push_back('{"rst_r4_cleared", 32'h0});
    sb.push_back('{"rst_r9_cleared", 32'h0});
    sb.push_back('{"rst_count_cleared", 32'h0});
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (rt_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rt_data_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
    @(negedge clk);
    rst = 1'b0;
    RegWrite_i = 1'b0;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    force dut.wr_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wr_count_q;
    #1;
    sb.push_back('{"wrap_preload", 32'hFFFFFFFF});
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
    drive(1'b1, 1'b0, 32'h5, 32'h0, 5'd7, 5'd7, 5'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
    sb.push_back('{"wrap_count", 32'h0});
    sb.push_back('{"wrap_r7", 32'h5});
    e = sb.pop_front(); total++;
    if (wr_count_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, wr_count_o, e.exp); else passed++;
    e = sb.pop_front(); total++;
    if (rs_data_o !== e.exp) $display("FAIL %s: got %h expected %h", e.name, rs_data_o, e.exp); else passed++;
  endtask

  initial begin
    rst           = 1'b1;
    RegWrite_i    = 1'b0;
    MemtoReg_i    = 1'b0;
    Result_i      = '0;
    MemData_i     = '0;
    target_data_i = '0;
    rs_addr_i     = '0;
    rt_addr_i     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_mux_commit();
    test_bypass();
    test_reg_zero();
    test_disabled_write();
    test_back_to_back();
    test_reset_mid_write();
    test_wrap();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
